// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges two writeback requesters onto one register-file write port.
//
// Ports:
//   CLK, RST              rising-edge clock, synchronous active-high reset
//   req0/addr0/data0      requester 0 (ALU writeback) request, destination, value
//   gnt0                  requester 0 accepted this cycle (combinational)
//   req1/addr1/data1      requester 1 (memory-load writeback) request, destination, value
//   gnt1                  requester 1 accepted this cycle (combinational)
//   writeEnable           registered register-file write strobe
//   writeAddress          registered register-file write address
//   writeData             registered register-file write data
//   lastGrant             index of the most recently granted requester
//   conflictCount         saturating count of cycles with both requests high
//
// Configuration:
//   RR_FAIR_EN defined    conflicts alternate, favouring the requester not granted last
//   RR_FAIR_EN undefined  requester 0 always wins a conflict
module regfile_write_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic [4:0]  addr0,
    input  logic [31:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [4:0]  addr1,
    input  logic [31:0] data1,
    output logic        gnt1,
    output logic        writeEnable,
    output logic [4:0]  writeAddress,
    output logic [31:0] writeData,
    output logic        lastGrant,
    output logic [15:0] conflictCount
);
    typedef enum logic {PTR0, PTR1} state_t;
    state_t      state_q, state_d;
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [15:0] conf_q;
    logic        pick0;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        xfer;
`ifdef RR_FAIR_EN
    // Requester 0 wins a conflict only when requester 1 was granted last.
    assign pick0 = (state_q == PTR1);
`else
    assign pick0 = 1'b1;
`endif
    // Grants are masked during reset so no transfer is acknowledged then.
    assign gnt0 = !RST && req0 && (!req1 || pick0);
    assign gnt1 = !RST && req1 && (!req0 || !pick0);
    assign xfer = gnt0 || gnt1;
    always_comb begin
        state_d  = state_q;
        sel_addr = gnt1 ? addr1 : addr0;
        sel_data = gnt1 ? data1 : data0;
        if (gnt0) state_d = PTR0;
        else if (gnt1) state_d = PTR1;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= PTR1;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            conf_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            // Writes to register 0 are accepted but never reach the register file.
            we_q    <= xfer && (sel_addr != 5'd0);
            if (xfer && sel_addr != 5'd0) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
            if (req0 && req1 && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
        end
    end
    assign writeEnable   = we_q;
    assign writeAddress  = waddr_q;
    assign writeData     = wdata_q;
    assign lastGrant     = (state_q == PTR1);
    assign conflictCount = conf_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [4:0]  addr0 = 5'd0, addr1 = 5'd0;
    logic [31:0] data0 = 32'd0, data1 = 32'd0;
    logic        gnt0, gnt1, writeEnable, lastGrant;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [15:0] conflictCount;
    int checks = 0;
    int failures = 0;

    regfile_write_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
        .lastGrant(lastGrant), .conflictCount(conflictCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [1:0] exp_g [4];
    logic       exp_lg_after;

    initial begin
`ifdef RR_FAIR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_lg_after = 1'b1;
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_lg_after = 1'b0;
`endif
        tick(); tick();
        RST = 1'b0;
        tick(); tick(); tick();
        #1;
        check("idle_we", writeEnable, 0);
        check("idle_lg", lastGrant, 1);
        check("idle_cc", conflictCount, 0);
        check("idle_gnt", {gnt1, gnt0}, 0);
        check("idle_wa", writeAddress, 0);
        check("idle_wd", writeData, 0);

        req0 = 1'b1; addr0 = 5'd5; data0 = 32'hDEADBEEF;
        #1 check("single_gnt", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0;
        check("single_we", writeEnable, 1);
        check("single_wa", writeAddress, 5);
        check("single_wd", writeData, 32'hDEADBEEF);
        check("single_lg", lastGrant, 0);
        tick();
        check("single_we_drop", writeEnable, 0);
        check("single_wa_hold", writeAddress, 5);

        req1 = 1'b1; addr1 = 5'd0; data1 = 32'h1234;
        #1 check("r0_gnt", {gnt1, gnt0}, 2'b10);
        tick();
        req1 = 1'b0;
        check("r0_we", writeEnable, 0);
        check("r0_wa", writeAddress, 5);
        check("r0_wd", writeData, 32'hDEADBEEF);
        check("r0_lg", lastGrant, 1);

        req0 = 1'b1; addr0 = 5'd3; data0 = 32'hAAAA0000;
        req1 = 1'b1; addr1 = 5'd7; data1 = 32'hBBBB1111;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("conf_gnt%0d", i), {gnt1, gnt0}, exp_g[i]);
            tick();
            check($sformatf("conf_we%0d", i), writeEnable, 1);
            check($sformatf("conf_wa%0d", i), writeAddress, exp_g[i][1] ? 7 : 3);
            check($sformatf("conf_wd%0d", i), writeData, exp_g[i][1] ? 32'hBBBB1111 : 32'hAAAA0000);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("conf_cc", conflictCount, 4);
        check("conf_lg", lastGrant, exp_lg_after);
        tick();

        RST = 1'b1; req0 = 1'b1; addr0 = 5'd9; data0 = 32'h55;
        for (int i = 0; i < 2; i++) begin
            #1 check($sformatf("rst_gnt%0d", i), {gnt1, gnt0}, 0);
            tick();
        end
        check("rst_we", writeEnable, 0);
        check("rst_wa", writeAddress, 0);
        check("rst_cc", conflictCount, 0);
        check("rst_lg", lastGrant, 1);
        RST = 1'b0;
        #1 check("post_rst_gnt", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0;
        check("post_rst_we", writeEnable, 1);
        check("post_rst_wa", writeAddress, 9);
        check("post_rst_wd", writeData, 32'h55);

        req0 = 1'b1; req1 = 1'b1; addr0 = 5'd1; addr1 = 5'd2;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", conflictCount, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sat_ffff%0d", i), conflictCount, 16'hFFFF);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("sat_hold", conflictCount, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port CLK, reset port RST.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 req0  input  1  requester 0 (ALU writeback) holds a write request.
REQ-005 addr0  input  5  requester 0 destination register number.
REQ-006 data0  input  32  requester 0 write value.
REQ-007 gnt0  output  1  requester 0 write accepted this cycle (combinational).
REQ-008 req1 / addr1 / data1 / gnt1  in/in/in/out  1/5/32/1  requester 1 (memory-load writeback), same meaning as requester 0.
REQ-009 writeEnable  output  1  register-file write strobe (registered).
REQ-010 writeAddress  output  5  register-file write address (registered).
REQ-011 writeData  output  32  register-file write data (registered).
REQ-012 lastGrant  output  1  index of the most recently granted requester (priority pointer).
REQ-013 conflictCount  output  16  saturating count of cycles in which req0 and req1 were both high.

Function
REQ-014 Handshake SHALL be valid/ready: a transfer occurs in any cycle where reqN and gntN are both high; the requester SHALL hold addrN/dataN stable while reqN is high and gntN is low.
REQ-015 At most one of gnt0/gnt1 SHALL be high in any cycle; gntN SHALL never be high while reqN is low.
REQ-016 Single request: gntN SHALL be high in the same cycle, with no idle cycle, so one requester sustains one write per cycle.
REQ-017 Both requesting: the grant SHALL go to requester (1 - lastGrant).
REQ-018 On each transfer, lastGrant SHALL load the granted index at the next edge; with no transfer, lastGrant SHALL hold.
REQ-019 A transfer in cycle N SHALL produce writeEnable=1, writeAddress=addrN, writeData=dataN in cycle N+1 (latency 1); writeEnable SHALL be 0 in any cycle not following a transfer.
REQ-020 A transfer with addrN=0 SHALL be granted normally but SHALL produce writeEnable=0 in cycle N+1, with writeAddress/writeData holding their previous values.
REQ-021 writeAddress/writeData SHALL hold their last values whenever writeEnable is 0.
REQ-022 conflictCount SHALL increment by 1 at each edge following a cycle with req0=req1=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-023 The state machine SHALL have two states, PTR0 (lastGrant=0) and PTR1 (lastGrant=1); its transitions SHALL be given only by REQ-018.

Reset
REQ-024 While RST is high, gnt0 and gnt1 SHALL be forced to 0 combinationally, so no transfer is acknowledged in a reset cycle.
REQ-025 At the edge with RST high: writeEnable=0, writeAddress=5'd0, writeData=32'd0, lastGrant=1 (requester 0 wins the first conflict), conflictCount=0.
REQ-026 Reset asserted while a request is pending SHALL drop nothing: the request stays un-granted and is granted after RST falls.

Configuration
REQ-027 Macro RR_FAIR_EN SHALL select the arbitration policy.
REQ-028 With RR_FAIR_EN defined, the block SHALL apply round-robin per REQ-017.
REQ-029 Without RR_FAIR_EN, requester 0 SHALL always win a conflict; lastGrant and conflictCount SHALL still update as specified.

Verification
REQ-030 Reset, then idle 3 cycles -> writeEnable=0, lastGrant=1, conflictCount=0, gnt0=gnt1=0.
REQ-031 req0=1, addr0=5, data0=32'hDEADBEEF for 1 cycle -> gnt0=1 same cycle; next cycle writeEnable=1, writeAddress=5, writeData=32'hDEADBEEF.
REQ-032 req0 and req1 held high 4 cycles (RR_FAIR_EN) -> grants 0,1,0,1; conflictCount=4; without the macro -> grants 0,0,0,0.
REQ-033 req1=1, addr1=0, data1=32'h1234 -> gnt1=1; next cycle writeEnable=0 and writeAddress/writeData unchanged.
REQ-034 req0=1 with RST=1 for 2 cycles, then RST=0 -> gnt0=0 during reset; gnt0=1 in the first cycle after reset.
REQ-035 Force conflictCount to 16'hFFFE, then apply 3 conflict cycles -> conflictCount=16'hFFFF and holds.
